// File: rtl/control_display_7seg_pkg.sv
// Shared constants and FSM state type for the 7-segment scan controller.
package control_display_7seg_pkg;

    localparam logic [4:0] COD_BLANCO  = 5'd16;
    localparam logic [4:0] COD_GUION   = 5'd17;
    localparam logic [6:0] SEG_APAGADO = 7'b000_0000;

    typedef enum logic {
        StGuarda,
        StEncendido
    } estado_t;

endpackage

// File: rtl/control_display_7seg_if.sv
// Application-side bundle: digit codes and load strobe in, scan outputs back.
interface control_display_7seg_if #(
    parameter int unsigned N_DIGITOS = 4
);

    logic [5*N_DIGITOS-1:0] dato_in;
    logic                   cargar;
    logic                   supr_ceros;
    logic [6:0]             segmentos;
    logic [N_DIGITOS-1:0]   anodos;
    logic [2:0]             digito_idx;
    logic                   fin_cuadro;

    modport master (
        output dato_in, cargar, supr_ceros,
        input  segmentos, anodos, digito_idx, fin_cuadro
    );

    modport slave (
        input  dato_in, cargar, supr_ceros,
        output segmentos, anodos, digito_idx, fin_cuadro
    );

endinterface

// File: rtl/control_display_7seg_hex.sv
// Hex_7segmentos decoder: 5-bit code to active-high pattern, a = MSB, g = LSB.
module control_display_7seg_hex
    import control_display_7seg_pkg::*;
(
    input  logic [4:0] codigo,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_APAGADO;
        case (codigo)
            5'h00: segmentos = 7'b111_1110;
            5'h01: segmentos = 7'b011_0000;
            5'h02: segmentos = 7'b110_1101;
            5'h03: segmentos = 7'b111_1001;
            5'h04: segmentos = 7'b011_0011;
            5'h05: segmentos = 7'b101_1011;
            5'h06: segmentos = 7'b101_1111;
            5'h07: segmentos = 7'b111_0000;
            5'h08: segmentos = 7'b111_1111;
            5'h09: segmentos = 7'b111_1011;
            5'h0A: segmentos = 7'b111_0111;
            5'h0B: segmentos = 7'b001_1111;
            5'h0C: segmentos = 7'b100_1110;
            5'h0D: segmentos = 7'b011_1101;
            5'h0E: segmentos = 7'b100_1111;
            5'h0F: segmentos = 7'b100_0111;
            COD_GUION: segmentos = 7'b000_0001;
            default: segmentos = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/control_display_7seg.sv
// Multiplexed N-digit 7-segment scanner with guard blanking, frame-aligned
// double buffering and optional leading-zero suppression.
module control_display_7seg
    import control_display_7seg_pkg::*;
#(
    parameter int unsigned N_DIGITOS       = 4,
    parameter int unsigned CICLOS_DIGITO   = 50000,
    parameter int unsigned CICLOS_GUARDA   = 64,
    parameter bit          SEG_ACTIVO_BAJO = 1'b0
) (
    input logic clk,
    input logic rst,
    control_display_7seg_if.slave bus
);

    localparam int unsigned CMAX = (CICLOS_DIGITO > CICLOS_GUARDA) ? CICLOS_DIGITO : CICLOS_GUARDA;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam logic [CW-1:0] ULT_GUARDA = CW'(CICLOS_GUARDA - 1);
    localparam logic [CW-1:0] ULT_DIGITO = CW'(CICLOS_DIGITO - 1);
    localparam logic [2:0]    ULT_IDX    = 3'(N_DIGITOS - 1);
    localparam logic [6:0]    SEG_RESET  = SEG_APAGADO ^ {7{SEG_ACTIVO_BAJO}};
    localparam logic [5*N_DIGITOS-1:0] TODO_BLANCO = {N_DIGITOS{COD_BLANCO}};

    estado_t                estado_q, estado_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic                   frontera;
    logic [5*N_DIGITOS-1:0] sombra_q, activo_q;
    logic                   fin_q;
    logic [6:0]             seg_q, seg_dec;
    logic [N_DIGITOS-1:0]   anodos_q, anodos_d;

    logic [39:0] activo_ext;
    logic [4:0]  efectivo [8];
    logic [4:0]  cod, codigo_sel;
    logic        todo_cero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= StGuarda;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        frontera = 1'b0;
        unique case (estado_q)
            StGuarda: begin
                if (cnt_q == ULT_GUARDA) begin
                    estado_d = StEncendido;
                    cnt_d    = '0;
                end
            end
            StEncendido: begin
                if (cnt_q == ULT_DIGITO) begin
                    estado_d = StGuarda;
                    cnt_d    = '0;
                    frontera = (idx_q == ULT_IDX);
                    idx_d    = (idx_q == ULT_IDX) ? 3'd0 : idx_q + 3'd1;
                end
            end
        endcase
        anodos_d = (estado_d == StEncendido) ? ~(N_DIGITOS'(1) << idx_d) : '1;
    end

    // Scan top-down so each digit knows whether everything above it is zero/blank.
    always_comb begin
        activo_ext = 40'(activo_q);
        todo_cero  = 1'b1;
        cod        = '0;
        for (int i = 7; i >= 0; i--) begin
            cod         = activo_ext[5*i +: 5];
            todo_cero   = todo_cero & ((cod == 5'd0) | (cod == COD_BLANCO));
            efectivo[i] = (bus.supr_ceros && todo_cero && i != 0) ? COD_BLANCO : cod;
        end
        codigo_sel = efectivo[idx_q];
    end

    control_display_7seg_hex u_hex (
        .codigo    (codigo_sel),
        .segmentos (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            sombra_q <= TODO_BLANCO;
            activo_q <= TODO_BLANCO;
            fin_q    <= 1'b0;
            seg_q    <= SEG_RESET;
            anodos_q <= '1;
        end else begin
            idx_q <= idx_d;
            if (bus.cargar) sombra_q <= bus.dato_in;
            // A strobe coinciding with the boundary bypasses the shadow copy.
            if (frontera) activo_q <= bus.cargar ? bus.dato_in : sombra_q;
            fin_q    <= frontera;
            seg_q    <= SEG_ACTIVO_BAJO ? ~seg_dec : seg_dec;
            anodos_q <= anodos_d;
        end
    end

    assign bus.segmentos  = seg_q;
    assign bus.anodos     = anodos_q;
    assign bus.digito_idx = idx_q;
    assign bus.fin_cuadro = fin_q;

endmodule

// File: doc/control_display_7seg.md
Name: control_display_7seg

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display. Drives one shared Hex_7segmentos decoder from a per-digit 5-bit code word. Sequences anode enables with a blanking guard interval between digits. Double-buffers the displayed value so updates never tear mid-frame, and optionally suppresses leading zeros. Sits between the application datapath and the board display pins.

Parameters:
N_DIGITOS, 4, number of digits scanned; legal range 2..8.
CICLOS_DIGITO, 50000, clk cycles each digit stays lit; must be >= 2.
CICLOS_GUARDA, 64, clk cycles with all anodes off between digits (anti-ghosting); must be >= 1.
SEG_ACTIVO_BAJO, 0, 1 = invert segment outputs at the pin register.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
dato_in  in  5*N_DIGITOS  digit codes; digit i is bits [5i+4:5i]; digit 0 is least significant. Codes: 0-15 hex, 16 blank, 17 dash, others blank
cargar  in  1  one-cycle strobe; captures dato_in into the shadow register
supr_ceros  in  1  level; 1 enables leading-zero suppression
segmentos  out  7  registered segment pattern; a = MSB, g = LSB
anodos  out  N_DIGITOS  registered one-hot anode enables, active-low
digito_idx  out  3  index of the digit currently selected
fin_cuadro  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst assertion.
- Reset values:
  - shadow and active registers: all digits = 16 (blank)
  - anodos = all 1s; segmentos = 0 (or all 1s if SEG_ACTIVO_BAJO)
  - digito_idx = 0; fin_cuadro = 0
  - FSM = GUARDA with counter = 0
- Shadow register: loads dato_in on any cycle cargar = 1. The last strobe before a frame boundary wins.
- Active register: copies the shadow register only at the frame boundary. If cargar is high in the boundary cycle itself, dato_in is copied directly, so the new value wins.
- FSM has two states, counter width $clog2(max(CICLOS_DIGITO, CICLOS_GUARDA)).
  - GUARDA:
    - anodos all 1s; counter counts 0..CICLOS_GUARDA-1.
    - On the last count, go to ENCENDIDO and clear the counter.
  - ENCENDIDO:
    - anodos[digito_idx] = 0, others 1; counter counts 0..CICLOS_DIGITO-1.
    - On the last count, go to GUARDA and clear the counter.
    - In the same cycle, digito_idx advances, wrapping N_DIGITOS-1 to 0.
- Frame boundary: the ENCENDIDO-to-GUARDA transition where digito_idx wraps to 0. In that cycle:
  - the active register updates;
  - fin_cuadro = 1 in the following cycle, for exactly one cycle.
- Frame period: N_DIGITOS*(CICLOS_GUARDA+CICLOS_DIGITO) cycles. The first digit 0 lights CICLOS_GUARDA cycles after rst deasserts.
- Segment path:
  - Decode the effective code of the active register at digito_idx combinationally, then register into segmentos every cycle.
  - Because digito_idx changes on entry to GUARDA, segmentos is stable one cycle after entering GUARDA. It is always valid before the anode turns on.
- Leading-zero suppression: with supr_ceros = 1, effective code of digit i (i >= 1) = 16 if every digit j >= i has code 0 or 16. Digit 0 is never suppressed, so 0000 displays as "   0". supr_ceros is sampled combinationally every cycle.
- Reset mid-scan: outputs return to reset values asynchronously. Scanning restarts from GUARDA, idx 0, with a blank display until the next cargar plus frame boundary.

Decomposition:
- Shared package/header:
  - code constants COD_BLANCO = 16, COD_GUION = 17;
  - FSM state encodings GUARDA / ENCENDIDO;
  - the 7-bit all-off segment constant.
- Sub-module: one instance of the existing Hex_7segmentos decoder on the effective-code mux output.
- Suppression and mux logic stay inline.

Test Plan (N_DIGITOS=4, CICLOS_DIGITO=8, CICLOS_GUARDA=2, SEG_ACTIVO_BAJO=0):
- Reset release, no cargar -> anodos = 1111 for 2 cycles, then 1110. segmentos = 0000000 throughout. fin_cuadro first pulses 40 cycles after release.
- cargar with dato_in = {3,2,1,0} -> from the next frame, per lit digit: idx0 1111110, idx1 0110000, idx2 1101101, idx3 1111001. Anodes 1110/1101/1011/0111, each for 8 cycles with 2 all-off cycles between.
- cargar mid-frame with {F,E,D,C} -> the current frame still shows the old value; the new value appears only after the fin_cuadro boundary. No mixed frame.
- supr_ceros = 1, dato_in = {0,0,7,0} -> digits 3 and 2 blank (0000000), digit 1 = 1110000, digit 0 = 1111110. With {0,0,0,0} only digit 0 shows 1111110.
- dato_in = {17,16,31,A} -> dash 0000001, blank, blank (out-of-range code), A 1110111.
- rst pulsed during ENCENDIDO of digit 2 -> anodos = 1111 and segmentos = 0 in the same cycle, without waiting for a clk edge. The scan restarts at idx 0 after the guard interval, showing blank.
